// File: rtl/gray_cnt_rx.sv
// gray_cnt_rx: per-channel synchroniser, gray-to-binary conversion, delta/upd and wide accumulator.
// Define GRAY_CNT_RX_ERR_CHK_EN to build the sticky multi-bit gray-change error flags.
module gray_cnt_rx #(
  parameter int W    = 8,
  parameter int CH   = 4,
  parameter int SYNC = 2,
  parameter int AW   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH*W-1:0]  gray_in,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CH*W-1:0]  cnt,
  output logic [CH*W-1:0]  delta,
  output logic [CH-1:0]    upd,
  output logic [CH*AW-1:0] acc,
  output logic [CH-1:0]    err,
  output logic             ready
);

  localparam int WCW = $clog2(SYNC + 2);

  logic [W-1:0]   sync_q  [CH][SYNC];
  logic [W-1:0]   cnt_q   [CH];
  logic [W-1:0]   delta_q [CH];
  logic [AW-1:0]  acc_q   [CH];
  logic [CH-1:0]  upd_q;
  logic [W-1:0]   bin     [CH];
  logic [W-1:0]   d       [CH];
  logic [WCW-1:0] warm_q;
  logic           ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++)
        for (int i = 0; i < SYNC; i++)
          sync_q[c][i] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        sync_q[c][0] <= gray_in[c*W +: W];
        for (int i = 1; i < SYNC; i++)
          sync_q[c][i] <= sync_q[c][i-1];
      end
    end
  end

  // Warm-up lasts SYNC+1 edges so the chain is fully loaded before counting starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q  <= '0;
      ready_q <= 1'b0;
    end else if (!ready_q) begin
      if (warm_q == WCW'(SYNC))
        ready_q <= 1'b1;
      else
        warm_q <= warm_q + WCW'(1);
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      bin[c] = '0;
      for (int i = 0; i < W; i++)
        bin[c][i] = ^(sync_q[c][SYNC-1] >> i);
      d[c] = bin[c] - cnt_q[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q <= '0;
      for (int c = 0; c < CH; c++) begin
        cnt_q[c]   <= '0;
        delta_q[c] <= '0;
        acc_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        cnt_q[c] <= bin[c];
        if (!ready_q) begin
          delta_q[c] <= '0;
          upd_q[c]   <= 1'b0;
          acc_q[c]   <= '0;
        end else begin
          delta_q[c] <= d[c];
          upd_q[c]   <= (d[c] != '0);
          acc_q[c]   <= clr ? AW'(d[c]) : acc_q[c] + AW'(d[c]);
        end
      end
    end
  end

`ifdef GRAY_CNT_RX_ERR_CHK_EN
  logic [W-1:0]  s_prev_q [CH];
  logic [CH-1:0] err_q;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      for (int c = 0; c < CH; c++)
        s_prev_q[c] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        s_prev_q[c] <= sync_q[c][SYNC-1];
        if (ready_q && ($countones(sync_q[c][SYNC-1] ^ s_prev_q[c]) > 1))
          err_q[c] <= 1'b1;
        else if (err_clr)
          err_q[c] <= 1'b0;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = '0;
`endif

  always_comb begin
    cnt   = '0;
    delta = '0;
    acc   = '0;
    for (int c = 0; c < CH; c++) begin
      cnt[c*W +: W]    = cnt_q[c];
      delta[c*W +: W]  = delta_q[c];
      acc[c*AW +: AW]  = acc_q[c];
    end
  end

  assign upd   = upd_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_gray_cnt_rx.sv
// tb_gray_cnt_rx: directed stimulus for gray_cnt_rx with a latency-based behavioural model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_gray_cnt_rx;

  localparam int W    = 8;
  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int AW   = 8;
  localparam int MODW = 1 << W;
  localparam int MODA = 1 << AW;
`ifdef GRAY_CNT_RX_ERR_CHK_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             err_clr = 1'b0;
  logic [CH*W-1:0]  gray_in = '0;
  logic [CH*W-1:0]  cnt;
  logic [CH*W-1:0]  delta;
  logic [CH-1:0]    upd;
  logic [CH*AW-1:0] acc;
  logic [CH-1:0]    err;
  logic             ready;

  int checks = 0;
  int failures = 0;

  int src      [CH];
  int samp     [CH][SYNC+2];
  int edges = 0;
  int mCnt     [CH];
  int mDelta   [CH];
  int mAcc     [CH];
  bit mUpd     [CH];
  bit mErr     [CH];
  bit mReady = 1'b0;
  int updCount [CH];

  gray_cnt_rx #(.W(W), .CH(CH), .SYNC(SYNC), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gray_in (gray_in),
    .clr     (clr),
    .err_clr (err_clr),
    .cnt     (cnt),
    .delta   (delta),
    .upd     (upd),
    .acc     (acc),
    .err     (err),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] toGray(input int v);
    logic [W-1:0] b;
    b = W'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input int value);
    src[ch] = value % MODW;
    gray_in[ch*W +: W] = toGray(src[ch]);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Outputs after edge n reflect the sample taken at edge n-SYNC; counting starts once ready.
  task automatic modelStep();
    int cur, prev, dv;
    bit wasReady;
    if (!rst_n) begin
      edges = 0;
      mReady = 1'b0;
      for (int c = 0; c < CH; c++) begin
        for (int i = 0; i < SYNC + 2; i++) samp[c][i] = 0;
        mCnt[c] = 0; mDelta[c] = 0; mAcc[c] = 0; mUpd[c] = 1'b0; mErr[c] = 1'b0;
      end
    end else begin
      wasReady = (edges >= SYNC + 1);
      for (int c = 0; c < CH; c++) begin
        for (int i = SYNC + 1; i > 0; i--) samp[c][i] = samp[c][i-1];
        samp[c][0] = src[c];
        cur  = samp[c][SYNC];
        prev = samp[c][SYNC+1];
        mCnt[c] = cur;
        if (wasReady) begin
          dv = (cur - prev + MODW) % MODW;
          mDelta[c] = dv;
          mUpd[c]   = (dv != 0);
          mAcc[c]   = clr ? (dv % MODA) : ((mAcc[c] + dv) % MODA);
`ifdef GRAY_CNT_RX_ERR_CHK_EN
          if ($countones(toGray(cur) ^ toGray(prev)) > 1) mErr[c] = 1'b1;
          else if (err_clr) mErr[c] = 1'b0;
`endif
        end else begin
          mDelta[c] = 0;
          mUpd[c]   = 1'b0;
          mAcc[c]   = 0;
        end
      end
      edges++;
      mReady = (edges >= SYNC + 1);
    end
  endtask

  task automatic checkOutput();
    checkVal("ready", 64'(ready), 64'(mReady));
    for (int c = 0; c < CH; c++) begin
      checkVal($sformatf("cnt[%0d]", c),   64'(cnt[c*W +: W]),   64'(mCnt[c]));
      checkVal($sformatf("delta[%0d]", c), 64'(delta[c*W +: W]), 64'(mDelta[c]));
      checkVal($sformatf("upd[%0d]", c),   64'(upd[c]),          64'(mUpd[c]));
      checkVal($sformatf("acc[%0d]", c),   64'(acc[c*AW +: AW]), 64'(mAcc[c]));
      checkVal($sformatf("err[%0d]", c),   64'(err[c]),          64'(mErr[c]));
      if (upd[c] === 1'b1) updCount[c]++;
    end
  endtask

  always @(posedge clk) begin
    modelStep();
    #1;
    checkOutput();
  end

  initial begin
    for (int c = 0; c < CH; c++) begin
      applyStimulus(c, 0);
      updCount[c] = 0;
    end
    applyStimulus(0, 37);
    applyStimulus(2, 254);
    waitCycles(2);
    checkVal("reset_cnt0", 64'(cnt[0 +: W]), 64'd0);
    checkVal("reset_ready", 64'(ready), 64'd0);
    rst_n = 1'b1;

    $display("[TB] warm-up with non-zero sources");
    waitCycles(2);
    checkVal("warm_ready_low", 64'(ready), 64'd0);
    waitCycles(1);
    checkVal("warm_ready_high", 64'(ready), 64'd1);
    checkVal("warm_cnt0", 64'(cnt[0 +: W]), 64'd37);
    checkVal("warm_acc0", 64'(acc[0 +: AW]), 64'd0);
    checkVal("warm_upd", 64'(upd), 64'd0);
    checkVal("warm_err", 64'(err), 64'd0);

    $display("[TB] channel 1 counts 0 to 5");
    updCount[1] = 0;
    for (int v = 1; v <= 5; v++) begin
      applyStimulus(1, v);
      waitCycles(3);
    end
    waitCycles(2);
    checkVal("ch1_upd_pulses", 64'(updCount[1]), 64'd5);
    checkVal("ch1_acc", 64'(acc[1*AW +: AW]), 64'd5);
    checkVal("ch1_cnt", 64'(cnt[1*W +: W]), 64'd5);

    $display("[TB] channel 2 wraps 254 to 1");
    applyStimulus(2, 255); waitCycles(3);
    applyStimulus(2, 0);   waitCycles(3);
    applyStimulus(2, 1);   waitCycles(3);
    checkVal("ch2_wrap_acc", 64'(acc[2*AW +: AW]), 64'd3);
    checkVal("ch2_wrap_cnt", 64'(cnt[2*W +: W]), 64'd1);

    $display("[TB] channel 3 accumulator wrap");
    for (int i = 1; i <= 256; i++) begin
      applyStimulus(3, i);
      waitCycles(1);
    end
    waitCycles(SYNC + 1);
    checkVal("ch3_acc_wrap0", 64'(acc[3*AW +: AW]), 64'd0);
    applyStimulus(3, 1);
    waitCycles(SYNC + 1);
    checkVal("ch3_acc_wrap1", 64'(acc[3*AW +: AW]), 64'd1);

    $display("[TB] clr coincident with increment");
    for (int v = 6; v <= 10; v++) begin
      applyStimulus(1, v);
      waitCycles(1);
    end
    waitCycles(3);
    checkVal("ch1_acc10", 64'(acc[1*AW +: AW]), 64'd10);
    applyStimulus(1, 11);
    waitCycles(2);
    clr = 1'b1;
    waitCycles(1);
    clr = 1'b0;
    checkVal("clr_acc1", 64'(acc[1*AW +: AW]), 64'd1);
    checkVal("clr_upd1", 64'(upd[1]), 64'd1);
    checkVal("clr_delta1", 64'(delta[1*W +: W]), 64'd1);
    checkVal("clr_acc0", 64'(acc[0 +: AW]), 64'd0);

    $display("[TB] multi-bit gray jump on channel 0");
    applyStimulus(0, 46);
    waitCycles(3);
    checkVal("jump_delta0", 64'(delta[0 +: W]), 64'd9);
    checkVal("jump_acc0", 64'(acc[0 +: AW]), 64'd9);
    checkVal("jump_err0", 64'(err[0]), 64'(ERR_EXP));
    waitCycles(4);
    checkVal("jump_err0_sticky", 64'(err[0]), 64'(ERR_EXP));
    err_clr = 1'b1;
    waitCycles(1);
    err_clr = 1'b0;
    checkVal("errclr_err0", 64'(err[0]), 64'd0);
    applyStimulus(0, 55);
    waitCycles(2);
    err_clr = 1'b1;
    waitCycles(1);
    err_clr = 1'b0;
    checkVal("setwins_err0", 64'(err[0]), 64'(ERR_EXP));
    checkVal("setwins_delta0", 64'(delta[0 +: W]), 64'd9);

    $display("[TB] reset mid-operation");
    rst_n = 1'b0;
    #1;
    checkVal("midrst_cnt", 64'(cnt), 64'd0);
    checkVal("midrst_acc", 64'(acc), 64'd0);
    checkVal("midrst_err", 64'(err), 64'd0);
    checkVal("midrst_ready", 64'(ready), 64'd0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(SYNC + 3);
    checkVal("rerun_ready", 64'(ready), 64'd1);
    checkVal("rerun_cnt0", 64'(cnt[0 +: W]), 64'd55);
    checkVal("rerun_acc0", 64'(acc[0 +: AW]), 64'd0);

    waitCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
